// File: rtl/dmul_rot_lfsr_param_if.sv
// Start/busy/done handshake and result bus of the rotating-LFSR stochastic multiplier.
//   start, mode, iA, iB : request side (driven by the master)
//   busy, done, oBit, oC: status/result side (driven by the multiplier)
interface dmul_rot_lfsr_param_if #(
  parameter int unsigned INWD = 8
);
  logic              start;
  logic              mode;
  logic [INWD-1:0]   iA;
  logic [INWD-1:0]   iB;
  logic              busy;
  logic              done;
  logic              oBit;
  logic [2*INWD-1:0] oC;

  modport master (
    output start, mode, iA, iB,
    input  busy, done, oBit, oC
  );

  modport slave (
    input  start, mode, iA, iB,
    output busy, done, oBit, oC
  );
endinterface

// File: rtl/dmul_rot_lfsr_param.sv
// Deterministic stochastic multiplier: two maximal-length LFSR streams, with the
// B stream held for one cycle per period so every (A-state, B-state) pair meets
// exactly once over P*P cycles (P = 2^INWD-1). The count of product ones is then
// exact: A*B (unipolar, AND) or A*B + (P-A)*(P-B) (bipolar, XNOR).
// Ports:
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset
//   bus  : slave side of dmul_rot_lfsr_param_if
//          start/mode/iA/iB in; busy/done (registered), oBit (from registers), oC out
module dmul_rot_lfsr_param #(
  parameter int unsigned     INWD  = 8,
  parameter logic [INWD-1:0] TAPS  = INWD'(8'hB8),
  parameter logic [INWD-1:0] SEEDA = INWD'(1),
  parameter logic [INWD-1:0] SEEDB = INWD'(1)
) (
  input  logic                  clk,
  input  logic                  rst,
  dmul_rot_lfsr_param_if.slave  bus
);

  localparam int unsigned CW = 2 * INWD;
  // Last phase / rotation index, P-1 = 2^INWD-2
  localparam logic [INWD-1:0] LAST = {{(INWD-1){1'b1}}, 1'b0};

  typedef enum logic {IDLE, RUN} state_t;

  state_t          state;
  logic [INWD-1:0] lfsr_a;
  logic [INWD-1:0] lfsr_b;
  logic [INWD-1:0] a_reg;
  logic [INWD-1:0] b_reg;
  logic            mode_reg;
  logic [INWD-1:0] pc;
  logic [INWD-1:0] rc;
  logic [CW-1:0]   c_reg;
  logic            busy_r;
  logic            done_r;

  logic            bit_a;
  logic            bit_b;
  logic            prod;

  function automatic logic [INWD-1:0] lfsr_next(input logic [INWD-1:0] s);
    return {s[INWD-2:0], ^(s & TAPS)};
  endfunction

  // Stream bits: LFSR states 1..P map to thresholds 0..P-1 against the operand
  assign bit_a = (lfsr_a - INWD'(1)) < a_reg;
  assign bit_b = (lfsr_b - INWD'(1)) < b_reg;
  assign prod  = (state == RUN) && (mode_reg ? ~(bit_a ^ bit_b) : (bit_a & bit_b));

  assign bus.busy = busy_r;
  assign bus.done = done_r;
  assign bus.oBit = prod;
  assign bus.oC   = c_reg;

  // Control FSM, stream generators and ones counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      lfsr_a   <= SEEDA;
      lfsr_b   <= SEEDB;
      a_reg    <= '0;
      b_reg    <= '0;
      mode_reg <= 1'b0;
      pc       <= '0;
      rc       <= '0;
      c_reg    <= '0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            a_reg    <= bus.iA;
            b_reg    <= bus.iB;
            mode_reg <= bus.mode;
            lfsr_a   <= SEEDA;
            lfsr_b   <= SEEDB;
            pc       <= '0;
            rc       <= '0;
            c_reg    <= '0;
            busy_r   <= 1'b1;
            state    <= RUN;
          end
        end
        RUN: begin
          c_reg  <= c_reg + CW'(prod);
          lfsr_a <= lfsr_next(lfsr_a);
          // Holding B on the last phase shifts its alignment to A by one each period
          if (pc != LAST) begin
            lfsr_b <= lfsr_next(lfsr_b);
            pc     <= pc + INWD'(1);
          end else begin
            pc <= '0;
            if (rc == LAST) begin
              rc     <= '0;
              busy_r <= 1'b0;
              done_r <= 1'b1;
              state  <= IDLE;
            end else begin
              rc <= rc + INWD'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmul_rot_lfsr_param.sv
// Bench for dmul_rot_lfsr_param: one INWD=8 operation runs in the background
// while an INWD=4 instance is exercised with boundary, random, ignored-start,
// reset and back-to-back operations. Results are compared with the closed-form
// products.
module tb_dmul_rot_lfsr_param;

  localparam int P8 = 255;
  localparam int P4 = 15;

  logic clk = 1'b0;
  logic rst8;
  logic rst4;

  always #5 clk = ~clk;

  dmul_rot_lfsr_param_if #(.INWD(8)) bus8 ();
  dmul_rot_lfsr_param_if #(.INWD(4)) bus4 ();

  dmul_rot_lfsr_param #(.INWD(8)) dut8 (
    .clk (clk),
    .rst (rst8),
    .bus (bus8)
  );

  dmul_rot_lfsr_param #(
    .INWD (4),
    .TAPS (4'hC),
    .SEEDA(4'h5),
    .SEEDB(4'hA)
  ) dut4 (
    .clk (clk),
    .rst (rst4),
    .bus (bus4)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Running totals sampled at each rising edge (values seen during the cycle)
  int cyc       = 0;
  int tot_busy8 = 0;
  int tot_done8 = 0;
  int tot_busy4 = 0;
  int tot_done4 = 0;
  int tot_ones4 = 0;

  always @(posedge clk) begin
    cyc       <= cyc + 1;
    tot_busy8 <= tot_busy8 + int'(bus8.busy);
    tot_done8 <= tot_done8 + int'(bus8.done);
    tot_busy4 <= tot_busy4 + int'(bus4.busy);
    tot_done4 <= tot_done4 + int'(bus4.done);
    tot_ones4 <= tot_ones4 + int'(bus4.busy & bus4.oBit);
  end

  function automatic int expect_c(input int p, input int a, input int b, input logic m);
    if (m) return a * b + (p - a) * (p - b);
    return a * b;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One INWD=4 operation from IDLE; optionally re-raises start mid-run
  task automatic run4(input logic [3:0] a, input logic [3:0] b, input logic m,
                      input string tag, input bit inject);
    int s_busy, s_ones, s_done, k, exp;
    exp = expect_c(P4, int'(a), int'(b), m);
    @(negedge clk);
    bus4.start = 1'b1;
    bus4.iA    = a;
    bus4.iB    = b;
    bus4.mode  = m;
    s_busy = tot_busy4;
    s_ones = tot_ones4;
    s_done = tot_done4;
    @(negedge clk);
    bus4.start = 1'b0;
    bus4.iA    = 4'($urandom);
    bus4.iB    = 4'($urandom);
    bus4.mode  = 1'($urandom);
    check({tag, "_accept"}, 64'(bus4.busy), 64'(1));
    k = 0;
    while (!bus4.done && k < 240) begin
      @(negedge clk);
      k++;
      if (inject && k == 100) begin
        bus4.start = 1'b1;
        bus4.iA    = ~a;
        bus4.iB    = ~b;
        bus4.mode  = ~m;
      end else if (inject && k == 101) begin
        bus4.start = 1'b0;
      end
    end
    check({tag, "_done"}, 64'(bus4.done), 64'(1));
    check({tag, "_latency"}, 64'(k), 64'(225));
    check({tag, "_oc"}, 64'(bus4.oC), 64'(exp));
    check({tag, "_run_cycles"}, 64'(tot_busy4 - s_busy), 64'(225));
    check({tag, "_obit_ones"}, 64'(tot_ones4 - s_ones), 64'(exp));
    @(negedge clk);
    check({tag, "_done_width"}, 64'(bus4.done), 64'(0));
    check({tag, "_done_count"}, 64'(tot_done4 - s_done), 64'(1));
    check({tag, "_oc_hold"}, 64'(bus4.oC), 64'(exp));
  endtask

  initial begin
    logic [7:0] a8, b8;
    int         exp8, c8, k;
    logic [3:0] ba[3];
    logic [3:0] bb[3];
    logic       bm[3];
    int         t0;

    bus8.start = 1'b0; bus8.mode = 1'b0; bus8.iA = '0; bus8.iB = '0;
    bus4.start = 1'b0; bus4.mode = 1'b0; bus4.iA = '0; bus4.iB = '0;
    rst8 = 1'b1;
    rst4 = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst8_busy", 64'(bus8.busy), 64'(0));
    check("rst8_done", 64'(bus8.done), 64'(0));
    check("rst8_obit", 64'(bus8.oBit), 64'(0));
    check("rst8_oc",   64'(bus8.oC),   64'(0));
    check("rst4_busy", 64'(bus4.busy), 64'(0));
    check("rst4_done", 64'(bus4.done), 64'(0));
    check("rst4_obit", 64'(bus4.oBit), 64'(0));
    check("rst4_oc",   64'(bus4.oC),   64'(0));
    rst8 = 1'b0;
    rst4 = 1'b0;

    // Long INWD=8 bipolar operation running in the background
    a8   = 8'($urandom);
    b8   = 8'($urandom);
    exp8 = expect_c(P8, int'(a8), int'(b8), 1'b1);
    @(negedge clk);
    bus8.start = 1'b1; bus8.iA = a8; bus8.iB = b8; bus8.mode = 1'b1;
    c8 = cyc;
    @(negedge clk);
    bus8.start = 1'b0;
    check("w8_accept", 64'(bus8.busy), 64'(1));
    repeat (100) @(negedge clk);
    bus8.start = 1'b1; bus8.iA = ~a8; bus8.iB = ~b8; bus8.mode = 1'b0;
    @(negedge clk);
    bus8.start = 1'b0;
    check("w8_still_busy", 64'(bus8.busy), 64'(1));

    // INWD=4 boundary operands
    run4(4'd0,  4'd0,  1'b0, "u_0x0",   1'b0);
    run4(4'd15, 4'd15, 1'b0, "u_15x15", 1'b0);
    run4(4'd0,  4'd9,  1'b0, "u_0x9",   1'b0);
    run4(4'd15, 4'd6,  1'b0, "u_15x6",  1'b0);
    run4(4'd0,  4'd0,  1'b1, "b_0x0",   1'b0);
    run4(4'd15, 4'd15, 1'b1, "b_15x15", 1'b0);
    run4(4'd0,  4'd15, 1'b1, "b_0x15",  1'b0);
    run4(4'd15, 4'd0,  1'b1, "b_15x0",  1'b0);

    for (int i = 0; i < 100; i++)
      run4(4'($urandom), 4'($urandom), 1'($urandom), $sformatf("rnd%0d", i), 1'b0);

    // Start raised mid-run is ignored
    run4(4'($urandom), 4'($urandom), 1'($urandom), "ignore", 1'b1);

    // Reset during a run, with a simultaneous start
    @(negedge clk);
    bus4.start = 1'b1; bus4.iA = 4'd11; bus4.iB = 4'd13; bus4.mode = 1'b0;
    @(negedge clk);
    bus4.start = 1'b0;
    repeat (100) @(negedge clk);
    rst4 = 1'b1;
    bus4.start = 1'b1;
    @(negedge clk);
    check("midrst_busy", 64'(bus4.busy), 64'(0));
    check("midrst_oc",   64'(bus4.oC),   64'(0));
    check("midrst_done", 64'(bus4.done), 64'(0));
    check("midrst_obit", 64'(bus4.oBit), 64'(0));
    rst4 = 1'b0;
    bus4.start = 1'b0;
    run4(4'd11, 4'd13, 1'b1, "post_rst", 1'b0);

    // Start held high: each done cycle accepts the next operation
    for (int i = 0; i < 3; i++) begin
      ba[i] = 4'($urandom);
      bb[i] = 4'($urandom);
      bm[i] = 1'($urandom);
    end
    @(negedge clk);
    bus4.start = 1'b1; bus4.iA = ba[0]; bus4.iB = bb[0]; bus4.mode = bm[0];
    t0 = cyc;
    for (int i = 0; i < 3; i++) begin
      k = 0;
      while (!bus4.done && k < 240) begin
        @(negedge clk);
        k++;
      end
      check($sformatf("b2b%0d_done", i), 64'(bus4.done), 64'(1));
      check($sformatf("b2b%0d_oc", i), 64'(bus4.oC),
            64'(expect_c(P4, int'(ba[i]), int'(bb[i]), bm[i])));
      check($sformatf("b2b%0d_spacing", i), 64'(cyc - t0), 64'(226));
      t0 = cyc;
      if (i < 2) begin
        bus4.iA = ba[i+1]; bus4.iB = bb[i+1]; bus4.mode = bm[i+1];
      end else begin
        bus4.start = 1'b0;
      end
      @(negedge clk);
      check($sformatf("b2b%0d_done_width", i), 64'(bus4.done), 64'(0));
      check($sformatf("b2b%0d_busy", i), 64'(bus4.busy), 64'(i < 2));
      if (i < 2) check($sformatf("b2b%0d_oc_clear", i), 64'(bus4.oC), 64'(0));
    end

    // Collect the INWD=8 result
    while (!bus8.done && (cyc - c8) < 65100) @(negedge clk);
    check("w8_done",       64'(bus8.done),   64'(1));
    check("w8_latency",    64'(cyc - c8),    64'(65026));
    check("w8_oc",         64'(bus8.oC),     64'(exp8));
    check("w8_run_cycles", 64'(tot_busy8),   64'(65025));
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check($sformatf("w8_hold%0d", i), 64'(bus8.oC), 64'(exp8));
    end
    check("w8_done_count", 64'(tot_done8), 64'(1));
    check("w8_idle_busy",  64'(bus8.busy), 64'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
